alu_seq: RTL and testbench

Parametrised, handshaked successor to the team's 16-bit combinational ALU. It keeps the same 6-bit `alufn` operation encoding and the same z/n/v flags, but generalises the datapath width. It registers results behind a valid/ready pair and replaces the single-cycle Wallace-tree multiplier with an iterative shift-add unit. It sits between the instruction-decode stage and writeback, and stalls upstream while a multiply is in flight or the result is not yet consumed.

---
 rtl/alu_seq_pkg.sv | 25 ++
 rtl/alu_seq_if.sv | 24 ++
 rtl/alu_seq_mul_iter.sv | 58 +++++
 rtl/alu_seq.sv | 170 +++++++++++++++++
 tb/tb_alu_seq.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/alu_seq_pkg.sv
// Shared encodings for alu_seq: alufn class/shift/compare codes and the FSM state type.
package alu_seq_pkg;

   localparam logic [1:0] CLS_ARITH = 2'b00;
   localparam logic [1:0] CLS_BOOL  = 2'b01;
   localparam logic [1:0] CLS_SHIFT = 2'b10;
   localparam logic [1:0] CLS_CMP   = 2'b11;

   localparam logic [1:0] SH_SHL = 2'b00;
   localparam logic [1:0] SH_SHR = 2'b01;
   localparam logic [1:0] SH_ALT = 2'b10;
   localparam logic [1:0] SH_SRA = 2'b11;

   localparam logic [1:0] CMP_NONE = 2'b00;
   localparam logic [1:0] CMP_EQ   = 2'b01;
   localparam logic [1:0] CMP_LT   = 2'b10;
   localparam logic [1:0] CMP_LE   = 2'b11;

   typedef enum logic {IDLE, MUL} state_t;

   function automatic logic is_mul(input logic [5:0] fn);
      return (fn[5:4] == CLS_ARITH) && fn[1];
   endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Request/result handshake bundle between decode, alu_seq and writeback.
interface alu_seq_if #(parameter int WIDTH = 16);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [5:0]       alufn;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out;
   logic             z;
   logic             n;
   logic             v;

   modport master (
      output in_valid, a, b, alufn, out_ready,
      input  in_ready, out_valid, out, z, n, v
   );

   modport slave (
      input  in_valid, a, b, alufn, out_ready,
      output in_ready, out_valid, out, z, n, v
   );
endinterface

// File: rtl/alu_seq_mul_iter.sv
// Iterative shift-add unsigned multiplier: one partial product per cycle, WIDTH steps,
// done pulses for one cycle once prod holds the full 2*WIDTH-bit product.
module mul_iter #(
   parameter int WIDTH = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] prod
);

   localparam int CW = $clog2(WIDTH);

   logic [WIDTH-1:0] mcand_p0;
   logic [WIDTH-1:0] hi_p0;
   logic [WIDTH-1:0] lo_p0;
   logic [CW-1:0]    cnt;
   logic [WIDTH:0]   psum;

   // The multiplier sits in lo and is shifted out as the product shifts in from the top.
   assign psum = {1'b0, hi_p0} + (lo_p0[0] ? {1'b0, mcand_p0} : {(WIDTH+1){1'b0}});
   assign prod = {hi_p0, lo_p0};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy <= 1'b0;
         done <= 1'b0;
         cnt  <= '0;
      end else begin
         done <= 1'b0;
         if (busy) begin
            cnt <= cnt + 1'b1;
            if (cnt == CW'(WIDTH-1)) begin
               busy <= 1'b0;
               done <= 1'b1;
            end
         end else if (start) begin
            busy <= 1'b1;
            cnt  <= '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (busy) begin
         {hi_p0, lo_p0} <= {psum, lo_p0[WIDTH-1:1]};
      end else if (start) begin
         mcand_p0 <= a;
         hi_p0    <= '0;
         lo_p0    <= b;
      end
   end

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle add/sub/bool/shift/compare, iterative multiply,
// result and z/n/v flags held in an output register behind valid/ready.
module alu_seq
   import alu_seq_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input logic        clk,
   input logic        rst_n,
   alu_seq_if.slave   bus
);

   localparam int SHW = $clog2(WIDTH);

   state_t state, state_nxt;

   logic                    in_rdy;
   logic                    mul_start;
   logic                    ld_alu;
   logic                    ld_mul;
   logic                    mul_busy;
   logic                    mul_done;
   logic [2*WIDTH-1:0]      mul_prod;

   logic [1:0]              cls;
   logic                    sub;
   logic signed [WIDTH-1:0] a_s;
   logic [WIDTH-1:0]        b_op;
   logic [WIDTH-1:0]        sum;
   logic                    fl_z, fl_n, fl_v;
   logic                    cmp_bit;
   logic [SHW-1:0]          shamt;
   logic [WIDTH-1:0]        res;

   logic                    hi_sel_p0;
   logic                    z_p0, n_p0, v_p0;
   logic [WIDTH-1:0]        res_p1;
   logic                    z_p1, n_p1, v_p1;
   logic                    vld_p1;

   function automatic logic [WIDTH-1:0] bool_op(input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] y,
                                                input logic [3:0]       tt);
      logic [WIDTH-1:0] r;
      r = '0;
      for (int i = 0; i < WIDTH; i++) r[i] = tt[{y[i], x[i]}];
      return r;
   endfunction

   // Flag adder: compares always subtract so lt/le/eq see a-b.
   assign cls   = bus.alufn[5:4];
   assign sub   = bus.alufn[0] || (cls == CLS_CMP);
   assign a_s   = bus.a;
   assign b_op  = sub ? ~bus.b : bus.b;
   assign sum   = bus.a + b_op + WIDTH'(sub);
   assign fl_z  = (sum == '0);
   assign fl_n  = sum[WIDTH-1];
   assign fl_v  = (bus.a[WIDTH-1] == b_op[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
   assign shamt = bus.b[SHW-1:0];

   always_comb begin
      cmp_bit = 1'b0;
      case (bus.alufn[2:1])
         CMP_EQ:  cmp_bit = fl_z;
         CMP_LT:  cmp_bit = fl_n ^ fl_v;
         CMP_LE:  cmp_bit = fl_z | (fl_n ^ fl_v);
         default: cmp_bit = 1'b0;
      endcase
   end

   always_comb begin
      res = '0;
      case (cls)
         CLS_ARITH: res = sum;
         CLS_BOOL:  res = bool_op(bus.a, bus.b, bus.alufn[3:0]);
         CLS_SHIFT: begin
            case (bus.alufn[1:0])
               SH_SHR:  res = bus.a >> shamt;
               SH_SRA:  res = a_s >>> shamt;
               default: res = bus.a << shamt;
            endcase
         end
         default:   res = {{(WIDTH-1){1'b0}}, cmp_bit};
      endcase
   end

   always_comb begin
      state_nxt = state;
      in_rdy    = 1'b0;
      mul_start = 1'b0;
      ld_alu    = 1'b0;
      ld_mul    = 1'b0;
      case (state)
         IDLE: begin
            in_rdy = !vld_p1 || bus.out_ready;
            if (bus.in_valid && in_rdy) begin
               if (is_mul(bus.alufn)) begin
                  mul_start = !mul_busy;
                  state_nxt = MUL;
               end else begin
                  ld_alu = 1'b1;
               end
            end
         end
         MUL: begin
            if (mul_done) begin
               ld_mul    = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   mul_iter #(.WIDTH(WIDTH)) u_mul (
      .clk   (clk),
      .rst_n (rst_n),
      .start (mul_start),
      .a     (bus.a),
      .b     (bus.b),
      .busy  (mul_busy),
      .done  (mul_done),
      .prod  (mul_prod)
   );

   // Stage p0: half-select and adder flags of an in-flight multiply.
   always_ff @(posedge clk) begin
      if (mul_start) begin
         hi_sel_p0 <= bus.alufn[0];
         z_p0      <= fl_z;
         n_p0      <= fl_n;
         v_p0      <= fl_v;
      end
   end

   // Stage p1: output register; a mul accept clears vld_p1 through the drain path.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         vld_p1 <= 1'b0;
         res_p1 <= '0;
         z_p1   <= 1'b0;
         n_p1   <= 1'b0;
         v_p1   <= 1'b0;
      end else begin
         state <= state_nxt;
         if (ld_alu) begin
            res_p1 <= res;
            z_p1   <= fl_z;
            n_p1   <= fl_n;
            v_p1   <= fl_v;
         end else if (ld_mul) begin
            res_p1 <= hi_sel_p0 ? mul_prod[2*WIDTH-1:WIDTH] : mul_prod[WIDTH-1:0];
            z_p1   <= z_p0;
            n_p1   <= n_p0;
            v_p1   <= v_p0;
         end
         if (ld_alu || ld_mul) vld_p1 <= 1'b1;
         else if (bus.out_ready) vld_p1 <= 1'b0;
      end
   end

   assign bus.in_ready  = in_rdy;
   assign bus.out_valid = vld_p1;
   assign bus.out       = res_p1;
   assign bus.z         = z_p1;
   assign bus.n         = n_p1;
   assign bus.v         = v_p1;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq at WIDTH=16 and WIDTH=32 with directed vectors.
module tb_alu_seq;

   typedef struct packed {
      logic [31:0] res;
      logic        z;
      logic        n;
      logic        v;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   passes = 0;
   int   cyc = 0;
   exp_t q16[$];
   exp_t q32[$];

   alu_seq_if #(.WIDTH(16)) bus();
   alu_seq_if #(.WIDTH(32)) bus32();

   alu_seq #(.WIDTH(16)) dut   (.clk(clk), .rst_n(rst_n), .bus(bus));
   alu_seq #(.WIDTH(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (rst_n && bus.out_valid && bus.out_ready) begin
         if (q16.size() == 0) begin
            checks++;
            $display("FAIL unexpected16: got result 0x%0h, expected none", bus.out);
         end else begin
            e = q16.pop_front();
            check("out16", 32'(bus.out), e.res);
            check("flags16", {29'd0, bus.z, bus.n, bus.v}, {29'd0, e.z, e.n, e.v});
         end
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (rst_n && bus32.out_valid && bus32.out_ready) begin
         if (q32.size() == 0) begin
            checks++;
            $display("FAIL unexpected32: got result 0x%0h, expected none", bus32.out);
         end else begin
            e = q32.pop_front();
            check("out32", bus32.out, e.res);
            check("flags32", {29'd0, bus32.z, bus32.n, bus32.v}, {29'd0, e.z, e.n, e.v});
         end
      end
   end

   // Holds the request until accepted; returns 1 time unit after the accept edge.
   task automatic issue(input bit wide, input logic [31:0] a, input logic [31:0] b,
                        input logic [5:0] fn, input logic [31:0] r,
                        input logic ez, input logic en, input logic ev, input bit push);
      int   t;
      exp_t e;
      if (wide) begin
         bus32.a = a; bus32.b = b; bus32.alufn = fn; bus32.in_valid = 1'b1;
      end else begin
         bus.a = a[15:0]; bus.b = b[15:0]; bus.alufn = fn; bus.in_valid = 1'b1;
      end
      t = 0;
      @(negedge clk);
      while (!(wide ? bus32.in_ready : bus.in_ready) && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (!(wide ? bus32.in_ready : bus.in_ready)) begin
         checks++;
         $display("FAIL accept_timeout: got in_ready 0 for %0d cycles, expected 1", t);
      end
      e.res = r; e.z = ez; e.n = en; e.v = ev;
      if (push) begin
         if (wide) q32.push_back(e);
         else q16.push_back(e);
      end
      @(posedge clk);
      #1;
      if (wide) bus32.in_valid = 1'b0;
      else bus.in_valid = 1'b0;
   endtask

   // Called right after a mul accept: busy window of w+1 samples, then the result.
   task automatic mul_window(input bit wide, input int w);
      int bad;
      bad = 0;
      for (int i = 0; i < w + 1; i++) begin
         @(negedge clk);
         if (wide ? (bus32.in_ready || bus32.out_valid) : (bus.in_ready || bus.out_valid)) bad++;
      end
      check(wide ? "mul32_busy_window" : "mul16_busy_window", bad, 0);
      @(negedge clk);
      check(wide ? "mul32_latency" : "mul16_latency",
            wide ? bus32.out_valid : bus.out_valid, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish, expected completion");
      $fatal(1);
   end

   initial begin
      int t0;
      int bad;
      bus.in_valid = 0; bus.a = '0; bus.b = '0; bus.alufn = '0; bus.out_ready = 1;
      bus32.in_valid = 0; bus32.a = '0; bus32.b = '0; bus32.alufn = '0; bus32.out_ready = 1;
      rst_n = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_out", 32'(bus.out), 0);
      check("rst_flags_valid", {28'd0, bus.out_valid, bus.z, bus.n, bus.v}, 0);
      @(posedge clk); #1 rst_n = 1;
      @(negedge clk);
      check("ready_after_reset", bus.in_ready, 1);
      @(posedge clk); #1;

      issue(0, 32'h7FFF, 32'h0001, 6'b000000, 32'h8000, 0, 1, 1, 1);
      @(negedge clk);
      check("add_latency", bus.out_valid, 1);
      @(posedge clk); #1;

      issue(0, 5, 5, 6'b000001, 0, 1, 0, 0, 1);
      issue(0, 5, 5, 6'b110111, 1, 1, 0, 0, 1);
      issue(0, 5, 5, 6'b110101, 0, 1, 0, 0, 1);

      t0 = cyc;
      issue(0, 32'h8001, 4, 6'b100000, 32'h0010, 0, 1, 0, 1);
      issue(0, 32'h8001, 4, 6'b100001, 32'h0800, 0, 0, 1, 1);
      issue(0, 32'h8001, 4, 6'b100011, 32'hF800, 0, 0, 1, 1);
      check("throughput_cycles", cyc - t0, 3);
      issue(0, 32'hF0F0, 32'hFF00, 6'b011000, 32'hF000, 0, 1, 0, 1);

      issue(0, 32'hFFFF, 32'hFFFF, 6'b000010, 32'h0001, 0, 1, 0, 1);
      mul_window(0, 16);
      @(posedge clk); #1;
      issue(0, 32'hFFFF, 32'hFFFF, 6'b000011, 32'hFFFE, 1, 0, 0, 1);
      mul_window(0, 16);
      @(posedge clk); #1;

      // Backpressure: result held, next request waits, then accept and drain together.
      bus.out_ready = 0;
      issue(0, 1, 2, 6'b000000, 3, 0, 0, 0, 1);
      bus.a = 16'd10; bus.b = 16'd3; bus.alufn = 6'b000001; bus.in_valid = 1;
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (bus.in_ready || !bus.out_valid || bus.out !== 16'd3) bad++;
      end
      check("backpressure_hold", bad, 0);
      @(posedge clk); #1 bus.out_ready = 1;
      @(negedge clk);
      check("release_ready", bus.in_ready, 1);
      begin
         exp_t e;
         e.res = 7; e.z = 0; e.n = 0; e.v = 0;
         q16.push_back(e);
      end
      @(posedge clk); #1 bus.in_valid = 0;
      @(negedge clk);
      check("no_bubble_valid", bus.out_valid, 1);
      @(posedge clk); #1;

      // Reset partway through a multiply: nothing may come out afterwards.
      issue(0, 3, 5, 6'b000010, 15, 0, 0, 0, 0);
      repeat (8) @(posedge clk);
      #2 rst_n = 0;
      #1;
      check("midmul_rst_out", 32'(bus.out), 0);
      check("midmul_rst_flags_valid", {28'd0, bus.out_valid, bus.z, bus.n, bus.v}, 0);
      @(posedge clk); #1 rst_n = 1;
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.out_valid || !bus.in_ready) bad++;
      end
      check("no_stale_result", bad, 0);
      @(posedge clk); #1;

      issue(1, 32'hFFFFFFFF, 32'hFFFFFFFF, 6'b000010, 32'h00000001, 0, 1, 0, 1);
      mul_window(1, 32);
      @(posedge clk); #1;
      issue(1, 32'hFFFFFFFF, 32'hFFFFFFFF, 6'b000011, 32'hFFFFFFFE, 1, 0, 0, 1);
      mul_window(1, 32);

      for (int i = 0; i < 50 && (q16.size() != 0 || q32.size() != 0); i++) @(negedge clk);
      check("drain16", q16.size(), 0);
      check("drain32", q32.size(), 0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
